// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiter and its helpers.
package uart_pkg;

  localparam int UART_DW = 8;
  localparam int TMO_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    LOCK = 2'd3
  } arb_state_e;

  // Next requester index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side byte streams plus the single stream toward uart_tx.
interface uart_tx_arb_if import uart_pkg::*; #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*UART_DW-1:0] req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic                    m_valid;
  logic [UART_DW-1:0]      m_data;
  logic                    m_ready;

  // master: requesters plus the uart_tx sink; slave: the arbiter.
  modport master (
    output req_valid, req_data, req_last, m_ready,
    input  req_ready, m_valid, m_data
  );

  modport slave (
    input  req_valid, req_data, req_last, m_ready,
    output req_ready, m_valid, m_data
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, modulo N.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          any
);

  // rot[k] is the request k positions after ptr, so priority is simply lowest k.
  logic [N-1:0] rot;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    assign sum     = {1'b0, ptr} + (IW+1)'(gi);
    assign idx     = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    assign rot[gi] = valid[idx];
  end

  logic [IW-1:0] off;
  logic [IW:0]   wsum;

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    wsum = {1'b0, ptr} + {1'b0, off};
    win  = (wsum >= (IW+1)'(N)) ? IW'(wsum - (IW+1)'(N)) : IW'(wsum);
  end

  assign any = |rot;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte sources, with optional message lock and idle timeout.
module uart_tx_arb import uart_pkg::*; #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cfg_lock_en,
  input  logic [TMO_W-1:0] cfg_lock_tmo,
  uart_tx_arb_if.slave     bus,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             lock_active,
  output logic             tmo_evt
);

  arb_state_e         state_reg, state_next;
  logic               m_valid_reg, m_valid_next;
  logic [UART_DW-1:0] m_data_reg, m_data_next;
  logic [IDW-1:0]     grant_reg, grant_next;
  logic [IDW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic               last_reg, last_next;
  logic               tmo_evt_reg, tmo_evt_next;

  logic [IDW-1:0]   pick_win;
  logic             pick_any;
  logic [IDW-1:0]   grant_inc;
  logic [TMO_W-1:0] tmo_inc;
  logic             take;
  logic [IDW-1:0]   take_id;
  logic [NREQ-1:0]  ready;

  uart_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_reg),
    .win   (pick_win),
    .any   (pick_any)
  );

  assign grant_inc = IDW'(wrap_inc(int'(grant_reg), NREQ));
  assign tmo_inc   = tmo_cnt_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    grant_next   = grant_reg;
    rr_ptr_next  = rr_ptr_reg;
    tmo_cnt_next = tmo_cnt_reg;
    last_next    = last_reg;
    tmo_evt_next = 1'b0;
    ready        = '0;
    take         = 1'b0;
    take_id      = pick_win;

    case (state_reg)
      IDLE: take = pick_any;
      SEND: begin
        if (bus.m_ready) begin
          m_valid_next = 1'b0;
          state_next   = GAP;
        end
      end
      // One dead cycle so uart_tx's stale tx_ready cannot accept a second byte.
      GAP: begin
        if (cfg_lock_en && !last_reg) begin
          tmo_cnt_next = '0;
          state_next   = LOCK;
        end else begin
          rr_ptr_next = grant_inc;
          state_next  = IDLE;
        end
      end
      LOCK: begin
        take_id = grant_reg;
        if (bus.req_valid[grant_reg]) begin
          take         = 1'b1;
          tmo_cnt_next = '0;
        end else if (!cfg_lock_en) begin
          rr_ptr_next = grant_inc;
          state_next  = IDLE;
        end else begin
          if (tmo_cnt_reg != '1) tmo_cnt_next = tmo_inc;
          if (cfg_lock_tmo != '0 && tmo_inc == cfg_lock_tmo) begin
            tmo_evt_next = 1'b1;
            rr_ptr_next  = grant_inc;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (take) begin
      // Gated by rst_b so no requester sees an accept while reset is held.
      ready[take_id] = rst_b;
      m_valid_next   = 1'b1;
      m_data_next    = bus.req_data[take_id*UART_DW +: UART_DW];
      grant_next     = take_id;
      last_next      = bus.req_last[take_id];
      state_next     = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg   <= IDLE;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      grant_reg   <= '0;
      rr_ptr_reg  <= '0;
      tmo_cnt_reg <= '0;
      last_reg    <= 1'b0;
      tmo_evt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      grant_reg   <= grant_next;
      rr_ptr_reg  <= rr_ptr_next;
      tmo_cnt_reg <= tmo_cnt_next;
      last_reg    <= last_next;
      tmo_evt_reg <= tmo_evt_next;
    end
  end

  assign bus.req_ready = ready;
  assign bus.m_valid   = m_valid_reg;
  assign bus.m_data    = m_data_reg;
  assign grant_id      = grant_reg;
  assign busy          = (state_reg != IDLE);
  assign lock_active   = (state_reg == LOCK);
  assign tmo_evt       = tmo_evt_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized and directed bench for uart_tx_arb: reference model predicts grants, scoreboard checks the byte stream.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             cfg_lock_en = 1'b0;
  logic [TMO_W-1:0] cfg_lock_tmo = '0;
  logic [IDW-1:0]   grant_id;
  logic             busy, lock_active, tmo_evt;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cfg_lock_en  (cfg_lock_en),
    .cfg_lock_tmo (cfg_lock_tmo),
    .bus          (bus.slave),
    .grant_id     (grant_id),
    .busy         (busy),
    .lock_active  (lock_active),
    .tmo_evt      (tmo_evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [UART_DW-1:0] data;
    int                 id;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]         src_q [NREQ][$];   // {last, data} per requester
  exp_t               exp_q [$];
  logic [UART_DW-1:0] out_log [$];
  int                 acc_cyc [$];
  int                 out_cyc [$];
  int                 present_pct = 100;
  int                 ready_mode = 0;    // 0: always ready, 1: random, 2: stalled
  logic [NREQ-1:0]    presenting = '0;
  logic [NREQ-1:0]    acc_seen = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_line(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endfunction

  function automatic void check_log(input string name, input logic [UART_DW-1:0] want[$]);
    chk({name, "_count"}, out_log.size(), want.size());
    foreach (want[i]) begin
      if (i < out_log.size()) chk($sformatf("%s_byte%0d", name, i), out_log[i], want[i]);
    end
    out_log.delete();
  endfunction

  // Requester and sink driver: hold each byte until accepted, then move on.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.m_ready   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_seen[i]) begin
          void'(src_q[i].pop_front());
          presenting[i] = 1'b0;
        end
        if (!presenting[i] && src_q[i].size() > 0 && $urandom_range(99) < present_pct)
          presenting[i] = 1'b1;
        bus.req_valid[i] = presenting[i];
        if (presenting[i]) begin
          bus.req_data[i*UART_DW +: UART_DW] = src_q[i][0][7:0];
          bus.req_last[i] = src_q[i][0][8];
        end
      end
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ($urandom_range(3) != 0);
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Reference model: byte in flight, one bubble after hand-off, optional message ownership.
  logic out_pending = 1'b0, bubble = 1'b0, owner_hold = 1'b0, cur_last = 1'b0, tmo_due = 1'b0;
  int   owner = 0, ptr = 0, idle_run = 0;

  initial forever begin
    int              cand;
    logic [NREQ-1:0] exp_rdy;
    logic            elig;
    @(negedge clk);
    acc_seen = bus.req_valid & bus.req_ready;
    if (|acc_seen) acc_cyc.push_back(cyc);
    if (!rst_b) begin
      chk("ready_in_reset", bus.req_ready, '0);
      out_pending = 1'b0; bubble = 1'b0; owner_hold = 1'b0; cur_last = 1'b0; tmo_due = 1'b0;
      owner = 0; ptr = 0; idle_run = 0;
      exp_q.delete();
    end else begin
      elig = !out_pending && !bubble;
      cand = -1;
      if (elig) begin
        if (owner_hold) begin
          if (bus.req_valid[owner]) cand = owner;
        end else begin
          for (int k = 0; k < NREQ; k++)
            if (cand < 0 && bus.req_valid[(ptr + k) % NREQ]) cand = (ptr + k) % NREQ;
        end
      end
      exp_rdy = '0;
      if (cand >= 0) exp_rdy[cand] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("m_valid", bus.m_valid, out_pending);
      chk("busy", busy, out_pending || bubble || owner_hold);
      chk("lock_active", lock_active, elig && owner_hold);
      chk("tmo_evt", tmo_evt, tmo_due);
      tmo_due = 1'b0;
      if (out_pending) begin
        if (bus.m_ready) begin
          out_pending = 1'b0;
          bubble = 1'b1;
        end
      end else if (bubble) begin
        bubble = 1'b0;
        if (cfg_lock_en && !cur_last) begin
          owner_hold = 1'b1;
          idle_run = 0;
        end else begin
          owner_hold = 1'b0;
          ptr = (owner + 1) % NREQ;
        end
      end else if (cand >= 0) begin
        exp_q.push_back('{data: src_q[cand][0][7:0], id: cand});
        owner = cand;
        cur_last = src_q[cand][0][8];
        out_pending = 1'b1;
        idle_run = 0;
      end else if (owner_hold) begin
        if (!cfg_lock_en) begin
          owner_hold = 1'b0;
          ptr = (owner + 1) % NREQ;
        end else begin
          if (idle_run < 65535) idle_run++;
          if (cfg_lock_tmo != 0 && idle_run == int'(cfg_lock_tmo)) begin
            tmo_due = 1'b1;
            owner_hold = 1'b0;
            ptr = (owner + 1) % NREQ;
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every downstream transfer.
  logic [UART_DW-1:0] prev_data = '0;
  logic               prev_stall = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_b) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.m_valid) chk("m_data_stable", bus.m_data, prev_data);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          fail_line("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          $display("xfer cycle %0d: req %0d byte 0x%02h (expected req %0d byte 0x%02h)",
                   cyc, grant_id, bus.m_data, e.id, e.data);
          chk("m_data", bus.m_data, e.data);
          chk("grant_id", grant_id, e.id);
        end
        out_log.push_back(bus.m_data);
        out_cyc.push_back(cyc);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_grant_id", grant_id, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lock_active", lock_active, 1'b0);
    chk("rst_tmo_evt", tmo_evt, 1'b0);
  endtask

  function automatic bit sources_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (sources_empty() && exp_q.size() == 0 && !busy && bus.req_valid == '0) done = 1'b1;
    end
    if (!done) fail_line(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_test();
    out_log.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  initial begin
    logic [UART_DW-1:0] w [$];
    int  c0, c1, len;
    bit  got;

    do_reset();

    // Single requester: latency and spacing between accepts.
    start_test();
    src_q[2].push_back({1'b1, 8'h55});
    src_q[2].push_back({1'b1, 8'h56});
    wait_drain("t1_drain", 200);
    chk("t1_acc_count", acc_cyc.size(), 2);
    if (acc_cyc.size() >= 2 && out_cyc.size() >= 1) begin
      chk("t1_accept_to_out", out_cyc[0] - acc_cyc[0], 1);
      chk("t1_accept_spacing", acc_cyc[1] - acc_cyc[0], 3);
    end
    w = {8'h55, 8'h56};
    check_log("t1", w);

    // All four valid continuously: strict rotation.
    do_reset();
    start_test();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) src_q[i].push_back({1'b1, 8'(8'hA0 + i)});
    wait_drain("t2_drain", 300);
    w = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_log("t2", w);

    // Message lock: req1's three bytes go back-to-back, then req3, then req0.
    do_reset();
    start_test();
    cfg_lock_en = 1'b1;
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h12});
    src_q[1].push_back({1'b1, 8'h13});
    @(negedge clk);
    src_q[0].push_back({1'b1, 8'h00});
    src_q[3].push_back({1'b1, 8'h30});
    wait_drain("t3_drain", 300);
    w = {8'h11, 8'h12, 8'h13, 8'h30, 8'h00};
    check_log("t3", w);

    // Lock timeout releases a stalled owner.
    do_reset();
    start_test();
    cfg_lock_en  = 1'b1;
    cfg_lock_tmo = 16'd10;
    src_q[0].push_back({1'b0, 8'h40});
    src_q[2].push_back({1'b1, 8'h42});
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (lock_active) begin got = 1'b1; c0 = cyc; end
    end
    if (!got) fail_line("t4_lock_wait");
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (tmo_evt) begin got = 1'b1; c1 = cyc; end
    end
    if (!got) fail_line("t4_tmo_wait");
    else chk("t4_tmo_delay", c1 - c0, 10);
    wait_drain("t4_drain", 200);
    w = {8'h40, 8'h42};
    check_log("t4", w);
    cfg_lock_en  = 1'b0;
    cfg_lock_tmo = '0;

    // Downstream stall for 50 cycles while others come and go.
    do_reset();
    start_test();
    ready_mode = 2;
    src_q[0].push_back({1'b1, 8'h77});
    @(negedge clk);
    present_pct = 50;
    for (int i = 1; i < NREQ; i++) src_q[i].push_back({1'b1, 8'(8'h70 + i)});
    repeat (50) @(negedge clk);
    chk("t5_hold_data", bus.m_data, 8'h77);
    ready_mode = 0;
    present_pct = 100;
    wait_drain("t5_drain", 300);
    w = {8'h77, 8'h71, 8'h72, 8'h73};
    check_log("t5", w);

    // Reset while a byte waits in SEND: it is dropped, lowest index wins afterwards.
    do_reset();
    start_test();
    ready_mode = 2;
    src_q[3].push_back({1'b1, 8'h99});
    repeat (3) @(negedge clk);
    src_q[1].push_back({1'b1, 8'h91});
    src_q[2].push_back({1'b1, 8'h92});
    repeat (2) @(negedge clk);
    chk("t6_pre_reset_valid", bus.m_valid, 1'b1);
    do_reset();
    ready_mode = 0;
    wait_drain("t6_drain", 300);
    w = {8'h91, 8'h92};
    check_log("t6", w);

    // Randomized traffic, first without and then with message lock.
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      start_test();
      cfg_lock_en = phase[0];
      present_pct = 60;
      ready_mode  = 1;
      for (int i = 0; i < NREQ; i++)
        for (int m = 0; m < 15; m++) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++)
            src_q[i].push_back({1'(b == len - 1), 8'($urandom_range(255))});
        end
      wait_drain("rand_drain", 20000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
